// File: rtl/gray_count_gen_if.sv
// rtl/gray_count_gen_if.sv - control inputs and count outputs of the Gray counter
// master drives the controls and observes the count; slave is the counter side.
interface gray_count_gen_if #(
  parameter int unsigned SIZE = 8
);
  logic            clr;
  logic            load;
  logic [SIZE-1:0] load_val;
  logic            en;
  logic            up;
  logic [SIZE-1:0] gray;
  logic [SIZE-1:0] bin_q;
  logic            tc;
  logic            changed;

  modport master (
    output clr, load, load_val, en, up,
    input  gray, bin_q, tc, changed
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output gray, bin_q, tc, changed
  );
endinterface

// File: rtl/gray_count_gen.sv
// rtl/gray_count_gen.sv - registered up/down counter with Gray, binary and terminal-count outputs
// Gray is re-encoded from the next binary value so both registers update on the same edge.
module gray_count_gen #(
  parameter int unsigned     SIZE      = 8,
  parameter bit              WRAP      = 1'b1,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  gray_count_gen_if.slave bus
);

  localparam logic [SIZE-1:0] ONE       = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] RESET_GRY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [SIZE-1:0] bin_q, bin_d;
  logic [SIZE-1:0] gray_q, gray_d;
  logic            changed_q, changed_d;
  logic            tc;

  function automatic logic [SIZE-1:0] to_gray(input logic [SIZE-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign tc = bus.up ? (&bin_q) : ~(|bin_q);

  always_comb begin
    bin_d = bin_q;
    if (bus.clr) begin
      bin_d = '0;
    end else if (bus.load) begin
      bin_d = bus.load_val;
    end else if (bus.en) begin
      // Saturating variant parks at the limit instead of wrapping.
      if (!WRAP && tc) begin
        bin_d = bin_q;
      end else if (bus.up) begin
        bin_d = bin_q + ONE;
      end else begin
        bin_d = bin_q - ONE;
      end
    end
    gray_d    = to_gray(bin_d);
    changed_d = (gray_d != gray_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= RESET_VAL;
      gray_q    <= RESET_GRY;
      changed_q <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      changed_q <= changed_d;
    end
  end

  assign bus.bin_q   = bin_q;
  assign bus.gray    = gray_q;
  assign bus.tc      = tc;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_gray_count_gen.sv
// tb/tb_gray_count_gen.sv - directed and model-checked bench for gray_count_gen
// u_wrap uses WRAP=1, u_sat uses WRAP=0; both share clock and reset.
module tb_gray_count_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gray_count_gen_if #(.SIZE(8)) bus_w ();
  gray_count_gen_if #(.SIZE(8)) bus_s ();

  gray_count_gen #(.SIZE(8), .WRAP(1'b1), .RESET_VAL(8'h00)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  gray_count_gen #(.SIZE(8), .WRAP(1'b0), .RESET_VAL(8'h00)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b, prev_g, m_bin, nb;
    logic       r_clr, r_load, r_en, r_up;
    logic [7:0] r_val;

    bus_w.clr = 0; bus_w.load = 0; bus_w.load_val = 0; bus_w.en = 1; bus_w.up = 1;
    bus_s.clr = 0; bus_s.load = 0; bus_s.load_val = 0; bus_s.en = 0; bus_s.up = 1;

    // 1: reset state, then free-running up count through the wrap
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin", bus_w.bin_q, 8'h00);
    chk("rst_gray", bus_w.gray, 8'h00);
    chk("rst_changed", bus_w.changed, 1'b0);
    chk("rst_tc", bus_w.tc, 1'b0);
    rst_n = 1'b1;
    prev_g = 8'h00;
    for (int k = 1; k <= 259; k++) begin
      tick();
      b = 8'(k % 256);
      chk("up_bin", bus_w.bin_q, b);
      chk("up_gray", bus_w.gray, gray_of(b));
      chk("up_hamming", $countones(prev_g ^ bus_w.gray), 1);
      chk("up_tc", bus_w.tc, (b == 8'hFF));
      chk("up_changed", bus_w.changed, 1'b1);
      prev_g = bus_w.gray;
    end

    // 2: load then count down through zero
    bus_w.en = 0; bus_w.load = 1; bus_w.load_val = 8'h05;
    tick();
    chk("load5_bin", bus_w.bin_q, 8'h05);
    bus_w.load = 0; bus_w.en = 1; bus_w.up = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      b = 8'((5 - k) & 255);
      chk("dn_bin", bus_w.bin_q, b);
      chk("dn_gray", bus_w.gray, gray_of(b));
      chk("dn_tc", bus_w.tc, (b == 8'h00));
      if (k == 6) chk("dn_gray_ff", bus_w.gray, 8'h80);
    end

    // 4: priority clr > load > en, and changed for no-op clr/load
    bus_w.clr = 1; bus_w.load = 1; bus_w.en = 1; bus_w.up = 1; bus_w.load_val = 8'h33;
    tick();
    chk("clr_wins", bus_w.bin_q, 8'h00);
    bus_w.clr = 0;
    tick();
    chk("load_beats_en", bus_w.bin_q, 8'h33);
    chk("load_changed", bus_w.changed, 1'b1);
    tick();
    chk("load_same_bin", bus_w.bin_q, 8'h33);
    chk("load_same_changed", bus_w.changed, 1'b0);
    bus_w.load = 0; bus_w.en = 0; bus_w.clr = 1;
    tick();
    chk("clr_bin", bus_w.bin_q, 8'h00);
    chk("clr_changed", bus_w.changed, 1'b1);
    tick();
    chk("clr_at0_changed", bus_w.changed, 1'b0);
    bus_w.clr = 0;
    tick();
    chk("hold_bin", bus_w.bin_q, 8'h00);
    chk("hold_changed", bus_w.changed, 1'b0);
    chk("tc_up_at0", bus_w.tc, 1'b0);
    bus_w.up = 0;
    #1;
    chk("tc_dn_at0_comb", bus_w.tc, 1'b1);

    // 5: asynchronous reset between edges at 0x40
    bus_w.load = 1; bus_w.load_val = 8'h3E;
    tick();
    bus_w.load = 0; bus_w.en = 1; bus_w.up = 1;
    tick();
    tick();
    chk("pre_rst_bin", bus_w.bin_q, 8'h40);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_bin", bus_w.bin_q, 8'h00);
    chk("async_rst_gray", bus_w.gray, 8'h00);
    chk("async_rst_changed", bus_w.changed, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_bin", bus_w.bin_q, 8'h01);
    tick();
    chk("post_rst_bin2", bus_w.bin_q, 8'h02);
    bus_w.en = 0;

    // 3: saturating instance at the top and bottom limits
    bus_s.load = 1; bus_s.load_val = 8'hFE;
    tick();
    chk("sat_load_bin", bus_s.bin_q, 8'hFE);
    bus_s.load = 0; bus_s.en = 1; bus_s.up = 1;
    tick();
    chk("sat_ff_bin", bus_s.bin_q, 8'hFF);
    chk("sat_ff_changed", bus_s.changed, 1'b1);
    chk("sat_ff_tc", bus_s.tc, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sat_hold_bin", bus_s.bin_q, 8'hFF);
      chk("sat_hold_gray", bus_s.gray, 8'h80);
      chk("sat_hold_changed", bus_s.changed, 1'b0);
      chk("sat_hold_tc", bus_s.tc, 1'b1);
    end
    bus_s.clr = 1;
    tick();
    chk("sat_clr_bin", bus_s.bin_q, 8'h00);
    bus_s.clr = 0; bus_s.up = 0;
    tick();
    chk("sat_low_bin", bus_s.bin_q, 8'h00);
    chk("sat_low_changed", bus_s.changed, 1'b0);
    chk("sat_low_tc", bus_s.tc, 1'b1);
    bus_s.en = 0;

    // 6: random controls against a reference model
    bus_w.clr = 1;
    tick();
    m_bin = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      r_clr  = ($urandom_range(0, 31) == 0);
      r_load = ($urandom_range(0, 15) == 0);
      r_en   = ($urandom_range(0, 3) != 0);
      r_up   = 1'($urandom_range(0, 1));
      r_val  = 8'($urandom_range(0, 255));
      bus_w.clr = r_clr; bus_w.load = r_load; bus_w.en = r_en;
      bus_w.up = r_up; bus_w.load_val = r_val;
      prev_g = gray_of(m_bin);
      if (r_clr) nb = 8'h00;
      else if (r_load) nb = r_val;
      else if (r_en) nb = r_up ? m_bin + 8'h01 : m_bin - 8'h01;
      else nb = m_bin;
      tick();
      chk("rnd_bin", bus_w.bin_q, nb);
      chk("rnd_gray", bus_w.gray, gray_of(nb));
      chk("rnd_changed", bus_w.changed, (gray_of(nb) != prev_g));
      chk("rnd_tc", bus_w.tc, r_up ? (nb == 8'hFF) : (nb == 8'h00));
      if (!r_clr && !r_load && r_en)
        chk("rnd_one_bit", $countones(prev_g ^ bus_w.gray), 1);
      m_bin = nb;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
